// File: rtl/align_shift_pipe.sv
// Two-stage significand alignment: right-shift by a clamped exponent difference,
// producing guard, round and sticky bits, with valid/ready flow control on both sides.
module align_shift_pipe #(
    parameter int W   = 24,
    parameter int SHW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_sig,
    input  logic [SHW-1:0] in_shamt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sig,
    output logic           out_guard,
    output logic           out_round,
    output logic           out_sticky
);

    localparam int EW = W + 2;
    localparam int CW = $clog2(EW + 1);

    logic          s1_valid;
    logic [W-1:0]  s1_sig;
    logic [CW-1:0] s1_s;
    logic [EW-1:0] s1_mask;

    logic          s2_adv;
    logic          s1_adv;
    logic [CW-1:0] s_clamp;
    logic [EW-1:0] mask_d;
    logic [EW-1:0] ext;
    logic [EW-1:0] shifted;
    logic          sticky_d;

    // Any shift of EW or more pushes every bit out, so EW is a sufficient ceiling.
    always_comb begin
        s_clamp = '0;
        if (int'(in_shamt) >= EW) begin
            s_clamp = CW'(EW);
        end else begin
            s_clamp = CW'(in_shamt);
        end
    end

    // Thermometer mask: each bit is a compare against s, not a shift of ones.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < EW; i++) begin
            mask_d[i] = (CW'(i) < s_clamp);
        end
    end

    assign ext      = {s1_sig, 2'b00};
    assign shifted  = ext >> s1_s;
    assign sticky_d = |(ext & s1_mask);

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sig   <= '0;
            s1_s     <= '0;
            s1_mask  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sig  <= in_sig;
                s1_s    <= s_clamp;
                s1_mask <= mask_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sig    <= '0;
            out_guard  <= 1'b0;
            out_round  <= 1'b0;
            out_sticky <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sig    <= shifted[EW-1:2];
                out_guard  <= shifted[1];
                out_round  <= shifted[0];
                out_sticky <= sticky_d;
            end
        end
    end

endmodule

// File: tb/tb_align_shift_pipe.sv
// Bench for align_shift_pipe: directed scenarios plus random traffic, scored
// against an arithmetic alignment model through an in-order expectation queue.
module tb_align_shift_pipe;

    localparam int W   = 24;
    localparam int SHW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_sig;
    logic [SHW-1:0] in_shamt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sig;
    logic           out_guard;
    logic           out_round;
    logic           out_sticky;

    int checks = 0;
    int errors = 0;

    // Packed result: {sig, guard, round, sticky}
    logic [W+2:0] exp_q[$];
    logic [W+3:0] held;
    logic         held_v = 1'b0;
    logic         last_acc;
    logic         last_in_ready;
    int           emitted = 0;

    align_shift_pipe #(.W(W), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sig    (in_sig),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_guard (out_guard),
        .out_round (out_round),
        .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W+2:0] ref_align(input logic [W-1:0] sig, input int sh);
        logic [63:0] e;
        logic [63:0] r;
        logic [63:0] lost;
        int          s;
        e    = 64'(sig) * 4;
        s    = (sh > W + 2) ? W + 2 : sh;
        r    = e / (64'd1 << s);
        lost = e % (64'd1 << s);
        return {r[W+1:0], (lost != 64'd0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+2:0] dut_result();
        return {out_sig, out_guard, out_round, out_sticky};
    endfunction

    // One clock: sample handshakes just before the edge, score, then return at the falling edge.
    task automatic cycle();
        logic [W+2:0] e;
        #4;
        last_in_ready = in_ready;
        last_acc      = rst_n && in_valid && in_ready;
        if (rst_n && held_v) begin
            chk("hold_stable", 64'({out_valid, dut_result()}), 64'(held));
        end
        held_v = rst_n && out_valid && !out_ready;
        held   = {out_valid, dut_result()};
        if (rst_n && out_valid && out_ready) begin
            emitted++;
            if (exp_q.size() == 0) begin
                chk("unexpected_emit", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(dut_result()), 64'(e));
            end
        end
        if (last_acc) exp_q.push_back(ref_align(in_sig, int'(in_shamt)));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] sig, input int sh,
                           input logic [W+2:0] exp);
        in_valid  = 1'b1;
        in_sig    = sig;
        in_shamt  = SHW'(sh);
        out_ready = 1'b1;
        cycle();
        chk({tag, "_acc"}, 64'(last_acc), 64'(1));
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        cycle();
        chk({tag, "_lat2"}, 64'(out_valid), 64'(1));
        chk({tag, "_val"}, 64'(dut_result()), 64'(exp));
        cycle();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ops[4];
        int           idx;
        int           n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sig    = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_outputs", 64'(dut_result()), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        run_one("pass",    24'hABCDEF, 0,   {24'hABCDEF, 3'b000});
        run_one("sh1",     24'hC00001, 1,   {24'h600000, 3'b100});
        run_one("sh4",     24'h000007, 4,   {24'h000000, 3'b011});
        run_one("sh25",    24'h800000, 25,  {24'h000000, 3'b010});
        run_one("sh26",    24'h800000, 26,  {24'h000000, 3'b001});
        run_one("sh255",   24'h800000, 255, {24'h000000, 3'b001});
        run_one("sh24",    24'hFFFFFF, 24,  {24'h000000, 3'b111});

        // Backpressure: four operands, consumer stalled for three cycles.
        ops[0] = 24'h123456; ops[1] = 24'hFEDCBA; ops[2] = 24'h0F0F0F; ops[3] = 24'h800001;
        idx = 0;
        n   = 0;
        while (idx < 4 && n < 20) begin
            in_valid  = 1'b1;
            in_sig    = ops[idx];
            in_shamt  = SHW'(idx * 3 + 1);
            out_ready = (n >= 3);
            cycle();
            if (n == 2) chk("bp_in_ready_low", 64'(last_in_ready), 64'(0));
            if (last_acc) idx++;
            n++;
        end
        chk("bp_all_accepted", 64'(idx), 64'(4));
        emitted = 0;
        drain("bp");

        // Reset with both stages occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sig    = 24'h55AA55;
        in_shamt  = 8'd3;
        cycle();
        cycle();
        chk("rm_full", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        exp_q.delete();
        held_v = 1'b0;
        chk("rm_out_valid", 64'(out_valid), 64'(0));
        chk("rm_in_ready", 64'(in_ready), 64'(1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rm_no_stale", 64'(out_valid), 64'(0));
        end

        // Random traffic with random consumer stalls.
        emitted = 0;
        n       = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sig    = W'($urandom);
            in_shamt  = ($urandom_range(0, 7) == 0) ? SHW'($urandom) : SHW'($urandom_range(0, 28));
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_acc) n++;
        end
        drain("rnd");
        chk("rnd_count", 64'(emitted), 64'(n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/align_shift_pipe.md
ALIGN_SHIFT_PIPE -- requirements
Module: align_shift_pipe

Interface
REQ-001 The module SHALL have parameter W, default 24, the significand width in bits (W >= 4).
REQ-002 The module SHALL have parameter SHW, default 8, the width of the shift-amount input.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit, meaning an operand is presented.
REQ-006 The module SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand this cycle.
REQ-007 The module SHALL have port in_sig, input, W bits, the significand to align.
REQ-008 The module SHALL have port in_shamt, input, SHW bits, the unsigned right-shift amount (exponent difference).
REQ-009 The module SHALL have port out_valid, output, 1 bit, meaning an aligned result is presented.
REQ-010 The module SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-011 The module SHALL have port out_sig, output, W bits, the aligned significand.
REQ-012 The module SHALL have ports out_guard, out_round and out_sticky, outputs, 1 bit each, the rounding bits.

Function
REQ-013 Transfer SHALL occur on an interface only in a cycle where valid and ready are both 1 at the rising edge.
REQ-014 Shift clamp SHALL be s = min(in_shamt, W+2); values >= W+2 behave identically to W+2.
REQ-015 The extended vector SHALL be E = {in_sig, 2'b00} of width W+2, and the result SHALL be R = E >> s (logical).
REQ-016 Outputs SHALL be out_sig = R[W+1:2], out_guard = R[1], out_round = R[0].
REQ-017 out_sticky SHALL be the OR of E & M, where M is a W+2-bit thermometer mask with M[i] = 1 iff i < s.
REQ-018 M SHALL be produced by a half-decode of s (ones below the index s) rather than by a shifter.
REQ-019 The pipeline SHALL have two register stages: S1 (latched sig, clamped s, mask) and S2 (shifted result plus sticky); each stage has a valid bit.
REQ-020 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when out_ready is held at 1.
REQ-021 Throughput SHALL be one operand per cycle with no bubbles while out_ready = 1.
REQ-022 S2 SHALL advance when !S2.valid or out_ready; S1 SHALL advance into S2 when S1.valid and S2 advances.
REQ-023 in_ready SHALL be !S1.valid or (S1 advances this cycle); it is combinational, with no path from in_valid.
REQ-024 While out_valid = 1 and out_ready = 0, out_sig, out_guard, out_round and out_sticky SHALL hold stable.
REQ-025 Under backpressure, at most 2 operands SHALL be held, and results SHALL emerge strictly in acceptance order, with none dropped or duplicated.
REQ-026 Simultaneous accept and emit on the same edge SHALL be lossless.
REQ-027 s = 0 SHALL pass the input through unchanged, with guard = round = sticky = 0.

Reset
REQ-028 While rst_n = 0 at a rising edge, S1.valid and S2.valid SHALL clear to 0, and out_valid SHALL be 0 from the next cycle.
REQ-029 Reset SHALL drive out_sig = 0 and out_guard = out_round = out_sticky = 0.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard in-flight operands, with no result emitted after reset.

Verification (W=24)
REQ-032 Scenario pass-through: in_sig=0xABCDEF, shamt=0 -> out_sig=0xABCDEF, g/r/s=0/0/0, out_valid 2 cycles after acceptance.
REQ-033 Scenario small shifts:
- in_sig=0xC00001, shamt=1 -> out_sig=0x600000, g=1, r=0, s=0.
- in_sig=0x000007, shamt=4 -> out_sig=0, g=0, r=1, s=1.
REQ-034 Scenario clamp boundary: in_sig=0x800000 with shamt=25 -> out_sig=0, g=0, r=1, s=0; the same input with shamt=26 and with shamt=255 -> out_sig=0, g=0, r=0, s=1.
REQ-035 Scenario backpressure: stream 4 operands with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, outputs stay stable, and all 4 results emerge in order once out_ready=1.
REQ-036 Scenario reset mid-flight: assert rst_n=0 with both stages full -> out_valid=0 next cycle, no stale result afterward, in_ready=1 after release.
REQ-037 Randomized check: random sig, shamt and ready patterns SHALL match a reference model bit-exactly and in order.
